branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Direction/target predictor and branch resolver around the execute-stage branch judge.
- Fetch side: combinational lookup of a direct-mapped BHT (2-bit saturating counters) plus BTB (tag + target), giving a next-PC guess.
- Execute side: consumes the judge's br_taken, the computed target and the prediction that travelled with the instruction.
- Updates the tables, and registers a one-cycle redirect on mispredict plus a mispredict statistics counter.

Parameters:
- IDX_BITS, 6, BHT/BTB index width; ENTRIES = 2**IDX_BITS, index = pc[IDX_BITS+1:2].
- TAG_BITS, 8, BTB tag width; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  fetch PC for lookup.
- if_pred_taken  out  1  predicted taken; 1 only on BTB hit with counter[1]=1.
- if_pred_target  out  32  BTB target when if_pred_taken, else if_pc+4.
- ex_valid  in  1  a control-transfer instruction resolves this cycle.
- ex_is_cond  in  1  conditional branch (1) vs JAL/JALR (0).
- ex_pc  in  32  PC of the resolving instruction.
- ex_br_taken  in  1  branch-judge result (always 1 for JAL/JALR).
- ex_target  in  32  computed taken target.
- ex_pred_taken  in  1  prediction made at fetch.
- ex_pred_target  in  32  predicted next PC made at fetch.
- flush  in  1  older-instruction flush; kills this cycle's resolve.
- redirect_valid  out  1  registered mispredict redirect pulse.
- redirect_pc  out  32  registered correct next PC.
- mispredict_cnt  out  32  total mispredicts since reset.

Behaviour:
- Reset (async, rst_n=0):
  - all counters = CNT_INIT, all BTB valid = 0, tags/targets = 0.
  - redirect_valid = 0, redirect_pc = 0, mispredict_cnt = 0.
  - if_pred_taken = 0 as a consequence of valid = 0.
  - Reset asserted mid-operation aborts any pending redirect immediately.
- Lookup:
  - purely combinational from the table registers, zero-cycle latency.
  - No bypass: a same-cycle update at the same index is not visible until the next cycle.
- Resolve (only when ex_valid=1 and flush=0):
  - actual_next = ex_br_taken ? ex_target : ex_pc+4 (32-bit wrap, no overflow flag).
  - mispredict = (actual_next != ex_pred_target); for conditional branches this also covers a direction mismatch.
  - Next edge: redirect_valid <= mispredict, redirect_pc <= actual_next; mispredict_cnt increments by 1 on mispredict and wraps 0xFFFFFFFF -> 0.
  - redirect_valid is a single-cycle pulse; when no qualifying resolve occurs, it returns to 0 and redirect_pc holds its value.
- Table update on the same edge, for ex_valid & !flush only:
  - Counter at ex_pc index: +1 saturating at 3 if ex_br_taken, else -1 saturating at 0.
  - JAL/JALR (ex_is_cond=0): counter forced to 2'b11.
  - BTB: if ex_br_taken, write valid=1, tag, target=ex_target. A not-taken outcome leaves the BTB entry unchanged.
- flush=1 with ex_valid=1: no update, no redirect, no count.
- Aliasing: a tag mismatch is a miss (not taken); an update with a different tag overwrites the entry. Counters are untagged and shared.

Decomposition:
- Shared define header: BHT counter encodings (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3) and default IDX_BITS/TAG_BITS, next to the existing ALU codes.
- One natural sub-module: sat_counter2, a combinational next-state function (cnt, taken, force_taken) -> cnt_next, instantiated once on the update path.

Test Plan:
- Reset then lookup if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104, all outputs 0.
- Resolve BEQ pc=0x100, taken, target=0x80, pred_taken=0, pred_target=0x104 -> next cycle redirect_valid=1, redirect_pc=0x80, mispredict_cnt=1. Lookup 0x100 then gives counter 2 and a BTB hit -> if_pred_taken=1, target=0x80.
- Three further taken resolves at 0x100 with the correct prediction -> no redirect, counter saturates at 3; one not-taken resolve -> redirect_pc=0x104, counter=2, still predicted taken.
- JAL at 0x200, target=0x400, correctly predicted -> counter forced to 3, no redirect, mispredict_cnt unchanged.
- ex_valid=1 with flush=1 and a mispredict -> redirect_valid stays 0, tables and counter unchanged.
- Lookup and update at the same index in the same cycle -> lookup returns the old value; the new value is visible next cycle. rst_n dropped while redirect_valid=1 -> output cleared immediately.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor and its neighbours: BHT counter
// encodings, default table geometry and the core's ALU operation codes.
package branch_predictor_pkg;

   localparam int BP_IDX_BITS = 6;
   localparam int BP_TAG_BITS = 8;

   typedef enum logic [1:0] {
      STRONG_NT = 2'd0,
      WEAK_NT   = 2'd1,
      WEAK_T    = 2'd2,
      STRONG_T  = 2'd3
   } bht_cnt_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter; unconditional
// jumps force the strongly-taken state.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] i_cnt,
   input  logic       i_taken,
   input  logic       i_force_taken,
   output logic [1:0] o_cnt_next
);

   always_comb begin
      o_cnt_next = i_cnt;
      if (i_force_taken) begin
         o_cnt_next = STRONG_T;
      end else if (i_taken) begin
         if (i_cnt != STRONG_T) o_cnt_next = i_cnt + 2'd1;
      end else begin
         if (i_cnt != STRONG_NT) o_cnt_next = i_cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB next-PC predictor with execute-stage resolution,
// registered mispredict redirect and mispredict statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         IDX_BITS = BP_IDX_BITS,
   parameter int         TAG_BITS = BP_TAG_BITS,
   parameter logic [1:0] CNT_INIT = WEAK_NT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic [31:0] if_pred_target,
   input  logic        ex_valid,
   input  logic        ex_is_cond,
   input  logic [31:0] ex_pc,
   input  logic        ex_br_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   input  logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] mispredict_cnt
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_LO  = IDX_BITS + 2;
   localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

   logic [1:0]          r_cnt    [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [31:0]         r_target [ENTRIES];
   logic [ENTRIES-1:0]  r_valid;

   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;
   logic [31:0] r_mispredict_cnt;

   logic [IDX_BITS-1:0] w_if_idx;
   logic [TAG_BITS-1:0] w_if_tag;
   logic                w_if_hit;
   logic [IDX_BITS-1:0] w_ex_idx;
   logic [TAG_BITS-1:0] w_ex_tag;
   logic                w_resolve;
   logic [31:0]         w_actual_next;
   logic                w_mispredict;
   logic [1:0]          w_cnt_next;
   logic                w_unused;

   // Fetch-side lookup reads registered state only, so an update landing on
   // the same index this cycle is seen from the next cycle onward.
   assign w_if_idx       = if_pc[IDX_BITS+1:2];
   assign w_if_tag       = if_pc[TAG_HI:TAG_LO];
   assign w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign if_pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
   assign if_pred_target = if_pred_taken ? r_target[w_if_idx] : pc_plus4(if_pc);

   assign w_ex_idx      = ex_pc[IDX_BITS+1:2];
   assign w_ex_tag      = ex_pc[TAG_HI:TAG_LO];
   assign w_resolve     = ex_valid && !flush;
   assign w_actual_next = ex_br_taken ? ex_target : pc_plus4(ex_pc);
   // Comparing full next-PCs also catches a direction mismatch on conditionals.
   assign w_mispredict  = (w_actual_next != ex_pred_target);

   assign w_unused = ^{if_pc[1:0], if_pc[31:TAG_HI+1], ex_pc[1:0], ex_pc[31:TAG_HI+1],
                       ex_pred_taken};

   sat_counter2 u_sat_counter2 (
      .i_cnt         (r_cnt[w_ex_idx]),
      .i_taken       (ex_br_taken),
      .i_force_taken (!ex_is_cond),
      .o_cnt_next    (w_cnt_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_cnt[i]    <= CNT_INIT;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
         end
      end else if (w_resolve) begin
         r_cnt[w_ex_idx] <= w_cnt_next;
         if (ex_br_taken) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         r_redirect_valid <= w_resolve && w_mispredict;
         if (w_resolve) begin
            r_redirect_pc <= w_actual_next;
            if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
         end
      end
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign mispredict_cnt = r_mispredict_cnt;

endmodule
